// File: rtl/rf_pkg.sv
// Shared register-file writeback types and sizes.
package rf_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NREQ = 3;

  typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; the pointer advances past each winner.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_any
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     cand;

  // Scan from the pointer and wrap; grants are suppressed while in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_q) + k) % N;
      if (!grant_any && rst_n && req[IdxW'(cand)]) begin
        grant[IdxW'(cand)] = 1'b1;
        grant_idx          = IdxW'(cand);
        grant_any          = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = IdxW'((32'(grant_idx) + 32'd1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin port sharing, one registered
// write per cycle, and a pending-write scoreboard for the issue stage.
module rf_wb_arbiter #(
  parameter int unsigned NREQ = rf_pkg::NREQ,
  parameter int unsigned XLEN = rf_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 rsv_valid,
  input  logic [4:0]           rsv_rd,
  output logic [31:0]          busy
);
  import rf_pkg::*;

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IdxW-1:0] grant_idx;
  logic            grant_any;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_fire;

  logic            rf_we_q;
  reg_idx_t        rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [NREG-1:0] busy_q, busy_d;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    sel_rd   = req_rd[32'(grant_idx)*5 +: 5];
    sel_data = req_data[32'(grant_idx)*XLEN +: XLEN];
  end

  // Writes to x0 are consumed but never reach the port, so outputs keep their last values.
  assign wr_fire = grant_any && (sel_rd != '0);

  // A same-cycle reservation must win over the clear from the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != '0)) begin
      busy_d[rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q <= wr_fire;
      if (wr_fire) begin
        rf_rd_q    <= sel_rd;
        rf_wdata_q <= sel_data;
      end
      busy_q <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of writeback requesters (0 = ALU, 1 = LSU, 2 = MUL/CSR).
REQ-002 Parameter XLEN, default 32: register data width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester writeback request.
REQ-006 req_rd  in  NREQx5  per-requester destination register index.
REQ-007 req_data  in  NREQxXLEN  per-requester write data.
REQ-008 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-009 rf_we  out  1  register-file write enable (drives RegWrite).
REQ-010 rf_rd  out  5  register-file write index.
REQ-011 rf_wdata  out  XLEN  register-file write data.
REQ-012 rsv_valid  in  1  issue stage reserves a destination register.
REQ-013 rsv_rd  in  5  register index being reserved.
REQ-014 busy  out  32  scoreboard; bit i = write to xi pending.

Function
REQ-015 req_ready SHALL be combinational: asserted only for the round-robin winner among asserted req_valid bits; all zero when no req_valid bit is set.
REQ-016 Round-robin: search starts at pointer ptr and wraps modulo NREQ; the first valid requester wins.
REQ-017 On a handshake (req_valid[i] and req_ready[i]), ptr SHALL become (i+1) mod NREQ; without a handshake ptr holds.
REQ-018 Every cycle at most one request is accepted; the write port never stalls, so a granted requester is always accepted.
REQ-019 An accepted request SHALL appear registered on rf_we/rf_rd/rf_wdata in the next cycle (latency 1); rf_we is 0 in cycles following no acceptance.
REQ-020 A request with req_rd = 0 SHALL be accepted normally, but the resulting output cycle has rf_we = 0.
REQ-021 rf_rd and rf_wdata SHALL hold their last values while rf_we = 0.
REQ-022 Requesters SHALL hold req_rd/req_data stable while req_valid is high and not accepted; the arbiter SHALL NOT depend on this for correctness.
REQ-023 Scoreboard: rsv_valid with rsv_rd != 0 sets busy[rsv_rd] at the next edge.
REQ-024 An rf_we cycle clears busy[rf_rd] at the next edge.
REQ-025 A set and a clear of the same index in the same cycle: set wins, so busy stays 1.
REQ-026 Reserving an already-busy register leaves it at 1; no counting, and a single write clears it.
REQ-027 busy[0] SHALL be constant 0.

Reset
REQ-028 Asserting rst_n low SHALL immediately force rf_we = 0, rf_rd = 0, rf_wdata = 0, busy = 0 and ptr = 0.
REQ-029 An accepted write that has not yet reached the outputs when reset asserts SHALL be discarded.
REQ-030 req_ready SHALL be all zero while rst_n is low.
REQ-031 Reset deassertion is synchronized externally; the first edge after release behaves as a normal cycle.

Structure
REQ-032 Shared package rf_pkg SHALL hold XLEN, NREG = 32, NREQ and typedef reg_idx_t (5-bit).
REQ-033 One sub-module, rr_arbiter, SHALL implement the parameterized round-robin grant and pointer; rf_wb_arbiter instantiates it and owns the output register and scoreboard.

Verification
REQ-034 Single request: req_valid = 001, rd = 5, data = 0xDEADBEEF -> req_ready = 001 the same cycle; next cycle rf_we = 1, rf_rd = 5, rf_wdata = 0xDEADBEEF.
REQ-035 All three requesters valid for 6 cycles from reset -> grant order 0,1,2,0,1,2, with one rf_we per cycle.
REQ-036 Scoreboard: rsv x7 at cycle 0, LSU write to x7 accepted at cycle 3 -> busy[7] = 1 in cycles 1-4 and 0 from cycle 5.
REQ-037 Same-cycle collision: rf_we to x9 and rsv_rd = 9 in the same cycle -> busy[9] = 1 after the edge.
REQ-038 x0 handling: a request with rd = 0 and rsv_rd = 0 -> accepted, rf_we = 0, busy[0] = 0.
REQ-039 Mid-operation reset: rst_n low for 1 cycle right after an acceptance -> rf_we never pulses, busy = 0, and the next grant goes to requester 0.
